// File: rtl/daq_frame_tx.sv
// daq_frame_tx: reads the measurement RAM in address order and streams one
// framed packet (header, count, MSB/LSB pairs, checksum) to the byte UART.
module daq_frame_tx #(
  parameter int         NSamples  = 32,
  parameter int         AddrWidth = 5,
  parameter int         DataWidth = 12,
  parameter logic [7:0] Header    = 8'hA5
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [DataWidth-1:0] dram_i,
  input  logic                 eot_i,
  output logic [AddrWidth-1:0] addr_o,
  output logic [7:0]           din_o,
  output logic                 stt_o,
  output logic                 busy_o,
  output logic                 eof_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_DONE
  } state_e;

  typedef enum logic [2:0] {
    B_HDR,
    B_CNT,
    B_MSB,
    B_LSB,
    B_CHK
  } kind_e;

  localparam logic [7:0] CntByte =
    8'(NSamples % 256);
  localparam logic [AddrWidth-1:0] LastIdx =
    AddrWidth'(NSamples - 1);

  state_e               state_q, state_d;
  kind_e                kind_q, kind_d;
  logic [AddrWidth-1:0] idx_q, idx_d;
  logic [7:0]           din_q, din_d;
  logic [7:0]           chk_q, chk_d;
  logic [7:0]           samp_q, samp_d;
  logic                 last_q, last_d;
  logic [7:0]           tx_byte;

  // Byte to emit for the current position in the frame.
  // MSB comes straight off the RAM port; LSB uses the captured sample so a
  // RAM write between the two bytes cannot tear it.
  always_comb begin
    tx_byte = 8'h00;
    unique case (kind_q)
      B_HDR:   tx_byte = Header;
      B_CNT:   tx_byte = CntByte;
      B_MSB:   tx_byte = 8'(dram_i >> 8);
      B_LSB:   tx_byte = samp_q;
      B_CHK:   tx_byte = chk_q;
      default: tx_byte = 8'h00;
    endcase
  end

  // Next-state logic: frame sequencing, checksum and sample index.
  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    idx_d   = idx_q;
    din_d   = din_q;
    chk_d   = chk_q;
    samp_d  = samp_q;
    last_d  = last_q;
    unique case (state_q)
      S_IDLE: begin
        idx_d = '0;
        if (start_i) begin
          state_d = S_LAUNCH;
          kind_d  = B_HDR;
          chk_d   = 8'h00;
          last_d  = 1'b0;
        end
      end
      S_LAUNCH: begin
        state_d = S_WAIT;
        din_d   = tx_byte;
        unique case (kind_q)
          B_CNT: chk_d = chk_q + tx_byte;
          B_MSB: begin
            chk_d  = chk_q + tx_byte;
            samp_d = dram_i[7:0];
          end
          B_LSB: begin
            chk_d  = chk_q + tx_byte;
            last_d = (idx_q == LastIdx);
            if (idx_q != LastIdx) begin
              idx_d = idx_q + 1'b1;
            end
          end
          default: ;
        endcase
      end
      S_WAIT: begin
        if (eot_i) begin
          state_d = S_LAUNCH;
          unique case (kind_q)
            B_HDR: kind_d = B_CNT;
            B_CNT: kind_d = B_MSB;
            B_MSB: kind_d = B_LSB;
            B_LSB: kind_d = last_q ? B_CHK : B_MSB;
            B_CHK: state_d = S_DONE;
            default: state_d = S_DONE;
          endcase
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register; reset aborts any frame in progress.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      kind_q  <= B_HDR;
      idx_q   <= '0;
      din_q   <= 8'h00;
      chk_q   <= 8'h00;
      samp_q  <= 8'h00;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      idx_q   <= idx_d;
      din_q   <= din_d;
      chk_q   <= chk_d;
      samp_q  <= samp_d;
      last_q  <= last_d;
    end
  end

  // Outputs decode directly from state so reset clears them at once.
  always_comb begin
    addr_o = idx_q;
    stt_o  = (state_q == S_LAUNCH);
    busy_o = (state_q != S_IDLE);
    eof_o  = (state_q == S_DONE);
    din_o  = (state_q == S_LAUNCH) ? tx_byte : din_q;
  end

endmodule

// File: tb/tb_daq_frame_tx.sv
// tb_daq_frame_tx: directed frames against a RAM model and a UART model;
// expected bytes/addresses are queued at start and popped on each stt_o.
module tb_daq_frame_tx;

  localparam int N = 32;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic        eot_i = 1'b0;
  logic [11:0] dram_i = 12'h000;
  logic [4:0]  addr_o;
  logic [7:0]  din_o;
  logic        stt_o;
  logic        busy_o;
  logic        eof_o;

  daq_frame_tx dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (start_i),
    .dram_i  (dram_i),
    .eot_i   (eot_i),
    .addr_o  (addr_o),
    .din_o   (din_o),
    .stt_o   (stt_o),
    .busy_o  (busy_o),
    .eof_o   (eof_o)
  );

  always #5 clk_i = ~clk_i;

  logic [11:0] mem [N];

  // RAM model: one cycle read latency.
  always @(posedge clk_i) dram_i <= mem[addr_o];

  typedef struct packed {
    logic [7:0] b;
    logic [4:0] a;
  } exp_t;

  exp_t q[$];

  int compared = 0;
  int mismatched = 0;
  int stt_cnt = 0;
  int eof_cnt = 0;
  int cyc = 0;
  int last_stt = 0;
  int tx_gap = 8;
  int tx_cnt = 0;
  bit chk_period = 1'b0;
  bit holding = 1'b0;
  bit prev_busy = 1'b0;
  bit prev_eof = 1'b0;
  logic [7:0] hold = 8'h00;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] want);
    compared++;
    assert (got === want) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  // Monitor plus UART model: checks every launched byte, din_o stability,
  // and answers each stt_o with eot_i after tx_gap cycles.
  always @(negedge clk_i) begin
    exp_t e;
    cyc++;
    if (!rst_i) begin
      holding = 1'b0;
      tx_cnt  = 0;
      eot_i   = 1'b0;
    end else begin
      if (prev_eof) chk("busy_after_eof", 32'(busy_o), 32'd0);
      if (stt_o) begin
        stt_cnt++;
        chk("stt_expected", 32'(q.size() > 0), 32'd1);
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("din_byte", 32'(din_o), 32'(e.b));
          chk("addr", 32'(addr_o), 32'(e.a));
        end
        if (chk_period && prev_busy)
          chk("stt_period", 32'(cyc - last_stt), 32'd3);
        last_stt = cyc;
        hold     = din_o;
        holding  = 1'b1;
      end else if (holding && busy_o) begin
        chk("din_hold", 32'(din_o), 32'(hold));
      end
      if (!busy_o) holding = 1'b0;
      if (eof_o) begin
        eof_cnt++;
        chk("eof_queue_empty", 32'(q.size()), 32'd0);
      end
      eot_i = 1'b0;
      if (stt_o) begin
        tx_cnt = tx_gap;
      end else if (tx_cnt > 0) begin
        tx_cnt--;
        if (tx_cnt == 0) eot_i = 1'b1;
      end
    end
    prev_busy = busy_o;
    prev_eof  = eof_o;
  end

  task automatic tick();
    @(negedge clk_i);
    #1;
  endtask

  task automatic push_frame();
    logic [7:0]  s;
    logic [11:0] m;
    q.push_back('{b: 8'hA5, a: 5'd0});
    q.push_back('{b: 8'h20, a: 5'd0});
    s = 8'h20;
    for (int k = 0; k < N; k++) begin
      m = mem[k];
      q.push_back('{b: {4'h0, m[11:8]}, a: 5'(k)});
      q.push_back('{b: m[7:0], a: 5'(k)});
      s = s + {4'h0, m[11:8]} + m[7:0];
    end
    q.push_back('{b: s, a: 5'(N - 1)});
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic wait_stt(input int n, input int lim);
    for (int i = 0; i < lim && stt_cnt < n; i++) tick();
    chk("wait_stt_timeout", 32'(stt_cnt >= n), 32'd1);
  endtask

  task automatic wait_eof(input int lim);
    for (int i = 0; i < lim && !eof_o; i++) tick();
    chk("wait_eof_timeout", 32'(eof_o), 32'd1);
  endtask

  task automatic wait_idle(input int lim);
    for (int i = 0; i < lim && busy_o; i++) tick();
    chk("wait_idle_timeout", 32'(busy_o), 32'd0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_addr"}, 32'(addr_o), 32'd0);
    chk({tag, "_din"}, 32'(din_o), 32'd0);
    chk({tag, "_stt"}, 32'(stt_o), 32'd0);
    chk({tag, "_busy"}, 32'(busy_o), 32'd0);
    chk({tag, "_eof"}, 32'(eof_o), 32'd0);
  endtask

  task automatic ramp();
    for (int k = 0; k < N; k++) mem[k] = 12'h100 + 12'(k);
  endtask

  initial begin
    int base;
    int eofs;
    ramp();
    #1 rst_i = 1'b0;
    repeat (3) tick();
    check_zero("reset");
    rst_i = 1'b1;
    repeat (2) tick();

    // Ramp frame; first-cycle timing and frame length.
    base = stt_cnt;
    eofs = eof_cnt;
    push_frame();
    pulse_start();
    chk("c1_busy", 32'(busy_o), 32'd1);
    chk("c1_stt", 32'(stt_o), 32'd1);
    chk("c1_din", 32'(din_o), 32'hA5);
    wait_eof(2000);
    chk("eof_busy", 32'(busy_o), 32'd1);
    tick();
    chk("idle_busy", 32'(busy_o), 32'd0);
    chk("ramp_bytes", 32'(stt_cnt - base), 32'd67);
    chk("ramp_eofs", 32'(eof_cnt - eofs), 32'd1);

    // All-ones samples, checksum E0.
    for (int k = 0; k < N; k++) mem[k] = 12'hFFF;
    tx_gap = 5;
    base = stt_cnt;
    push_frame();
    pulse_start();
    wait_idle(2000);
    chk("ones_bytes", 32'(stt_cnt - base), 32'd67);

    // Fastest transmitter: stt_o every 3 cycles.
    ramp();
    tx_gap = 2;
    chk_period = 1'b1;
    base = stt_cnt;
    push_frame();
    pulse_start();
    wait_idle(1000);
    chk_period = 1'b0;
    chk("fast_bytes", 32'(stt_cnt - base), 32'd67);

    // Starts during a frame and in DONE are ignored.
    tx_gap = 4;
    base = stt_cnt;
    eofs = eof_cnt;
    push_frame();
    pulse_start();
    wait_stt(base + 5, 200);
    pulse_start();
    wait_stt(base + 40, 1000);
    pulse_start();
    wait_eof(1000);
    pulse_start();
    chk("ign_bytes", 32'(stt_cnt - base), 32'd67);
    chk("ign_eofs", 32'(eof_cnt - eofs), 32'd1);
    chk("ign_busy", 32'(busy_o), 32'd0);
    push_frame();
    pulse_start();
    wait_idle(1000);
    chk("second_bytes", 32'(stt_cnt - base), 32'd134);
    chk("second_eofs", 32'(eof_cnt - eofs), 32'd2);

    // Reset during the 10th byte's WAIT.
    tx_gap = 8;
    base = stt_cnt;
    eofs = eof_cnt;
    push_frame();
    pulse_start();
    wait_stt(base + 10, 500);
    tick();
    rst_i = 1'b0;
    #1;
    check_zero("abort");
    q.delete();
    repeat (3) tick();
    rst_i = 1'b1;
    repeat (30) tick();
    chk("abort_no_stt", 32'(stt_cnt - base), 32'd10);
    chk("abort_no_eof", 32'(eof_cnt - eofs), 32'd0);
    push_frame();
    pulse_start();
    wait_idle(2000);
    chk("abort_next", 32'(stt_cnt - base), 32'd77);

    // RAM write between MSB and LSB of sample 3.
    ramp();
    base = stt_cnt;
    push_frame();
    pulse_start();
    wait_stt(base + 9, 500);
    mem[3] = 12'hABC;
    wait_idle(2000);
    chk("tear_bytes", 32'(stt_cnt - base), 32'd67);
    chk("tear_queue", 32'(q.size()), 32'd0);
    ramp();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
